// File: rtl/tp84_dl_ctrl.sv
// TP84 ROM download controller: routes HPS index-0 bytes to ROM regions and holds the core in reset.
// Optional TP84_DL_CHECKSUM_EN adds a mod-256 checksum of written ROM bytes.
module tp84_dl_ctrl #(
  parameter int          RST_HOLD   = 16,
  parameter logic [24:0] EXPECT_LEN = 25'h18000
) (
  input  logic        clk_49m,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [3:0]  rom_we,
  output logic [14:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic [15:0] dip_sw,
  output logic        is_set3,
  output logic        core_reset_n,
  output logic        dl_busy,
  output logic        dl_error
`ifdef TP84_DL_CHECKSUM_EN
  ,
  output logic [7:0]  checksum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_HOLD
  } state_t;

  localparam logic [15:0] HOLD_LAST = 16'(RST_HOLD - 1);
  localparam logic [24:0] ROM_END   = 25'h20000;

  state_t      state_q, state_d;
  logic [15:0] hold_q, hold_d;
  logic [24:0] cnt_q, cnt_d, cnt_base;
  logic        err_q, err_d;
  logic [3:0]  we_q, we_d;
  logic [14:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        busy_q, busy_d;
  logic        rst_n_q, rst_n_d;
  logic [15:0] dip_q = '0;
  logic [15:0] dip_d;
  logic        set3_q = 1'b0;
  logic        set3_d;
  logic        prev_dl_q = 1'b0;
  logic [7:0]  csum_q, csum_d;

  logic dl_rise, dl_fall, idx0, start, loading, rom_wr;

  always_comb begin
    dl_rise  = ioctl_download & ~prev_dl_q;
    dl_fall  = ~ioctl_download & prev_dl_q;
    idx0     = (ioctl_index == 8'd0);
    start    = ((state_q == S_IDLE) || (state_q == S_HOLD))
               && dl_rise && idx0;
    loading  = start || (state_q == S_LOAD);
    rom_wr   = loading && ioctl_wr && idx0;
    cnt_base = start ? '0 : cnt_q;

    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_base;
    err_d   = start ? 1'b0 : err_q;
    we_d    = '0;
    addr_d  = addr_q;
    data_d  = data_q;
    csum_d  = start ? 8'd0 : csum_q;
    dip_d   = dip_q;
    set3_d  = set3_q;

    if (rom_wr) begin
      cnt_d = (&cnt_base) ? cnt_base : cnt_base + 25'd1;
      if (ioctl_addr < ROM_END) begin
        we_d   = 4'b0001 << ioctl_addr[16:15];
        addr_d = ioctl_addr[14:0];
        data_d = ioctl_dout;
        csum_d = csum_d + ioctl_dout;
      end else begin
        err_d = 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (dl_fall) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (cnt_q != EXPECT_LEN) err_d = 1'b1;
        state_d = S_HOLD;
        hold_d  = '0;
      end
      S_HOLD: begin
        if (start) begin
          state_d = S_LOAD;
        end else if (hold_q == HOLD_LAST) begin
          state_d = S_IDLE;
        end else begin
          hold_d = hold_q + 16'd1;
        end
      end
      default: state_d = S_HOLD;
    endcase

    rst_n_d = (state_d == S_IDLE);
    busy_d  = (state_d == S_LOAD) || (state_d == S_CHECK);

    // Side-channel bytes are captured in every state, independent of the FSM.
    if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr < 25'd2) begin
      if (ioctl_addr[0]) dip_d[15:8] = ioctl_dout;
      else               dip_d[7:0]  = ioctl_dout;
    end
    if (ioctl_wr && ioctl_index == 8'd1 && ioctl_addr == 25'd0)
      set3_d = ioctl_dout[0];
  end

  always_ff @(posedge clk_49m) begin
    if (reset) begin
      state_q <= S_HOLD;
      hold_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      we_q    <= '0;
      busy_q  <= 1'b0;
      rst_n_q <= 1'b0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      rst_n_q <= rst_n_d;
      csum_q  <= csum_d;
    end
    prev_dl_q <= ioctl_download;
    addr_q    <= addr_d;
    data_q    <= data_d;
    dip_q     <= dip_d;
    set3_q    <= set3_d;
  end

  assign rom_we       = we_q;
  assign rom_addr     = addr_q;
  assign rom_data     = data_q;
  assign dip_sw       = dip_q;
  assign is_set3      = set3_q;
  assign core_reset_n = rst_n_q;
  assign dl_busy      = busy_q;
  assign dl_error     = err_q;

`ifdef TP84_DL_CHECKSUM_EN
  assign checksum = csum_q;
`else
  logic unused_csum;
  assign unused_csum = ^csum_q;
`endif

endmodule

// File: tb/tb_tp84_dl_ctrl.sv
// Randomized bench for tp84_dl_ctrl against a transaction-level reference model.
module tb_tp84_dl_ctrl;

  localparam int          HOLD = 16;
  localparam logic [24:0] ELEN = 25'd64;

  localparam int P_IDLE  = 0;
  localparam int P_LOAD  = 1;
  localparam int P_CHECK = 2;
  localparam int P_HOLD  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [7:0]  ioctl_index = '0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [3:0]  rom_we;
  logic [14:0] rom_addr;
  logic [7:0]  rom_data;
  logic [15:0] dip_sw;
  logic        is_set3;
  logic        core_reset_n;
  logic        dl_busy;
  logic        dl_error;
`ifdef TP84_DL_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  tp84_dl_ctrl #(
    .RST_HOLD  (HOLD),
    .EXPECT_LEN(ELEN)
  ) dut (
    .clk_49m       (clk),
    .reset         (reset),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_index   (ioctl_index),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .rom_we        (rom_we),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .dip_sw        (dip_sw),
    .is_set3       (is_set3),
    .core_reset_n  (core_reset_n),
    .dl_busy       (dl_busy),
    .dl_error      (dl_error)
`ifdef TP84_DL_CHECKSUM_EN
    ,
    .checksum      (checksum)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int          m_phase = P_HOLD;
  int          m_left  = HOLD;
  longint      m_count = 0;
  bit          m_err   = 0;
  logic [3:0]  m_we    = '0;
  logic [14:0] m_addr  = '0;
  logic [7:0]  m_data  = '0;
  logic [7:0]  m_csum  = '0;
  logic [15:0] m_dip   = '0;
  bit          m_set3  = 0;
  bit          m_prev  = 0;
  bit          model_on = 0;

  always @(posedge clk) begin
    bit rise, fall, start, loading;
    rise   = ioctl_download && !m_prev;
    fall   = !ioctl_download && m_prev;
    m_prev = ioctl_download;
    if (ioctl_wr && ioctl_index == 254 && ioctl_addr < 2) begin
      if (ioctl_addr == 1) m_dip[15:8] = ioctl_dout;
      else                 m_dip[7:0]  = ioctl_dout;
    end
    if (ioctl_wr && ioctl_index == 1 && ioctl_addr == 0)
      m_set3 = ioctl_dout[0];
    m_we = '0;
    if (reset) begin
      m_phase = P_HOLD;
      m_left  = HOLD;
      m_count = 0;
      m_err   = 0;
      m_csum  = 0;
    end else begin
      start = (m_phase == P_IDLE || m_phase == P_HOLD)
              && rise && ioctl_index == 0;
      loading = start || m_phase == P_LOAD;
      if (start) begin
        m_count = 0;
        m_err   = 0;
        m_csum  = 0;
      end
      if (loading && ioctl_wr && ioctl_index == 0) begin
        if (m_count < 64'd33554431) m_count++;
        if (ioctl_addr < 25'h20000) begin
          m_we   = 4'(1 << (ioctl_addr / 25'h8000));
          m_addr = 15'(ioctl_addr % 25'h8000);
          m_data = ioctl_dout;
          m_csum = m_csum + ioctl_dout;
        end else begin
          m_err = 1;
        end
      end
      if (start) begin
        m_phase = P_LOAD;
      end else if (m_phase == P_LOAD) begin
        if (fall) m_phase = P_CHECK;
      end else if (m_phase == P_CHECK) begin
        if (m_count != longint'(ELEN)) m_err = 1;
        m_phase = P_HOLD;
        m_left  = HOLD;
      end else if (m_phase == P_HOLD) begin
        m_left--;
        if (m_left == 0) m_phase = P_IDLE;
      end
    end
    #1;
    if (model_on) begin
      check("core_reset_n", 32'(core_reset_n), 32'(m_phase == P_IDLE));
      check("dl_busy", 32'(dl_busy),
            32'(m_phase == P_LOAD || m_phase == P_CHECK));
      check("dl_error", 32'(dl_error), 32'(m_err));
      check("rom_we", 32'(rom_we), 32'(m_we));
      check("dip_sw", 32'(dip_sw), 32'(m_dip));
      check("is_set3", 32'(is_set3), 32'(m_set3));
      if (m_we != 0) begin
        check("rom_addr", 32'(rom_addr), 32'(m_addr));
        check("rom_data", 32'(rom_data), 32'(m_data));
      end
`ifdef TP84_DL_CHECKSUM_EN
      check("checksum", 32'(checksum), 32'(m_csum));
`endif
    end
  end

  task automatic wr_byte(input logic [7:0] idx, input logic [24:0] a,
                         input logic [7:0] d);
    ioctl_index = idx;
    ioctl_addr  = a;
    ioctl_dout  = d;
    ioctl_wr    = 1'b1;
    @(negedge clk);
    ioctl_wr    = 1'b0;
  endtask

  // Index-0 download of n bytes; optional directed byte, out-of-range
  // byte and mid-load reset. Measures reset release when requested.
  task automatic dl_run(input int n, input bit inject, input bit oor,
                        input int abort_at, input bit measure);
    bit          together;
    logic [24:0] a;
    logic [7:0]  d;
    int          k;
    ioctl_index    = 8'd0;
    ioctl_download = 1'b1;
    together = 1'($urandom % 2);
    if (!together) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
      d = 8'($urandom);
      a = 25'($urandom_range(0, 32'h1FFFF));
      if (inject && i == 1) begin
        a = 25'h08001;
        d = 8'hA5;
      end
      if (oor && i == 2) a = 25'h20000 + 25'($urandom_range(0, 255));
      wr_byte(8'd0, a, d);
      if (inject && i == 1) begin
        check("we_08001", 32'(rom_we), 32'h2);
        check("addr_08001", 32'(rom_addr), 32'h0001);
        check("data_08001", 32'(rom_data), 32'hA5);
      end
      if (oor && i == 2) begin
        check("oor_no_we", 32'(rom_we), 32'h0);
        check("oor_error", 32'(dl_error), 32'h1);
      end
      repeat ($urandom % 3) @(negedge clk);
    end
    ioctl_download = 1'b0;
    if (measure) begin
      @(posedge clk);
      k = 0;
      do begin
        @(posedge clk);
        #2;
        k++;
      end while (!core_reset_n && k < 40);
      check("release_cycles", 32'(k), 32'd17);
    end else begin
      repeat (20) @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    int n, ab;
    bit oor;
    @(negedge clk);
    model_on = 1;
    reset    = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_release", 32'(core_reset_n), 32'h1);

    wr_byte(8'd254, 25'd0, 8'h3F);
    wr_byte(8'd254, 25'd1, 8'hC1);
    check("dip_c13f", 32'(dip_sw), 32'hC13F);
    check("dip_no_reset", 32'(core_reset_n), 32'h1);
    wr_byte(8'd1, 25'd0, 8'h01);
    check("set3", 32'(is_set3), 32'h1);

    dl_run(int'(ELEN), 1, 0, -1, 1);
    check("good_len_err", 32'(dl_error), 32'h0);

    dl_run(int'(ELEN) - 1, 0, 0, -1, 1);
    check("short_len_err", 32'(dl_error), 32'h1);

    ioctl_index    = 8'd254;
    ioctl_download = 1'b1;
    @(negedge clk);
    wr_byte(8'd254, 25'd0, 8'h5A);
    ioctl_download = 1'b0;
    repeat (3) @(negedge clk);
    check("err_sticky", 32'(dl_error), 32'h1);
    check("idx254_no_reset", 32'(core_reset_n), 32'h1);

    dl_run(int'(ELEN), 0, 1, -1, 1);
    check("oor_sticky", 32'(dl_error), 32'h1);

    dl_run(40, 0, 0, 10, 0);

    for (int it = 0; it < 14; it++) begin
      n   = $urandom_range(int'(ELEN) - 2, int'(ELEN) + 2);
      oor = ($urandom % 5) == 0;
      ab  = (($urandom % 4) == 0) ? $urandom_range(3, n - 1) : -1;
      dl_run(n, 0, oor, ab, ab < 0);
      wr_byte(8'd254, 25'($urandom % 3), 8'($urandom));
      wr_byte(8'd1, 25'($urandom % 2), 8'($urandom));
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
